// File: rtl/execute_multdiv_ctrl_if.sv
// ============================================================================
// Module   : execute_multdiv_ctrl_if
// Brief    : Start/operand/result handshake between the execute-stage
//            multdiv sequencer (master) and the iterative multdiv unit (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface execute_multdiv_ctrl_if;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_resultRDY;
    logic [31:0] md_result;
    logic        md_exception;

    modport master (
        output md_ctrl_mult, md_ctrl_div, md_operandA, md_operandB,
        input  md_resultRDY, md_result, md_exception
    );

    modport slave (
        input  md_ctrl_mult, md_ctrl_div, md_operandA, md_operandB,
        output md_resultRDY, md_result, md_exception
    );
endinterface

`default_nettype wire

// File: rtl/execute_multdiv_ctrl.sv
// ============================================================================
// Module   : execute_multdiv_ctrl
// Brief    : Issues mul/div from execute to the iterative multdiv unit, stalls
//            the pipeline until the result returns. Optional watchdog:
//            define MULTDIV_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_multdiv_ctrl #(
    parameter logic [4:0]  MUL_ALUOP      = 5'b00110,
    parameter logic [4:0]  DIV_ALUOP      = 5'b00111,
    parameter logic [31:0] MUL_STATUS     = 32'd4,
    parameter logic [31:0] DIV_STATUS     = 32'd5,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] TIMEOUT_STATUS = 32'd6
) (
    input  wire logic        clock,
    input  wire logic        reset_n,
    input  wire logic        insn_valid,
    input  wire logic [31:0] insn,
    input  wire logic [31:0] operandA,
    input  wire logic [31:0] operandB,
    input  wire logic        flush,
    execute_multdiv_ctrl_if.master md,
    output logic             stall,
    output logic             result_valid,
    output logic [31:0]      result,
    output logic [4:0]       result_rd,
    output logic             exception_valid,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [4:0] c_STATUS_RD = 5'd30;

    state_t     r_state;
    logic       r_is_div;
    logic [4:0] r_rd;

    logic w_md_hit;
    logic w_hit_div;
    logic w_stall;
    logic w_timeout;
    logic w_unused_insn;

    assign w_hit_div = (insn[6:2] == DIV_ALUOP);
    assign w_md_hit  = insn_valid & (insn[31:27] == 5'b0_0000)
                     & ((insn[6:2] == MUL_ALUOP) | w_hit_div);
    assign w_unused_insn = ^{insn[21:7], insn[1:0]};

`ifdef MULTDIV_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_CNT_W-1:0] r_cnt;

    // WAIT->DRAIN only happens on flush, so that is the one in-set entry to clear on.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if ((r_state != S_WAIT && r_state != S_DRAIN)
                     || (r_state == S_WAIT && flush)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign w_timeout = (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^{TIMEOUT_STATUS, 32'(TIMEOUT_CYCLES)};
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:  w_stall = w_md_hit & ~flush;
            S_ISSUE: w_stall = 1'b1;
            S_WAIT:  w_stall = 1'b1;
            S_DRAIN: w_stall = w_md_hit;
            default: w_stall = 1'b0;
        endcase
    end

    // Gated by reset so every output reads 0 while reset_n is low.
    assign stall = w_stall & reset_n;
    assign busy  = (r_state != S_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_is_div        <= 1'b0;
            r_rd            <= 5'd0;
            md.md_ctrl_mult <= 1'b0;
            md.md_ctrl_div  <= 1'b0;
            md.md_operandA  <= 32'd0;
            md.md_operandB  <= 32'd0;
            result_valid    <= 1'b0;
            result          <= 32'd0;
            result_rd       <= 5'd0;
            exception_valid <= 1'b0;
        end else begin
            md.md_ctrl_mult <= 1'b0;
            md.md_ctrl_div  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_md_hit && !flush) begin
                        md.md_operandA  <= operandA;
                        md.md_operandB  <= operandB;
                        r_rd            <= insn[26:22];
                        r_is_div        <= w_hit_div;
                        md.md_ctrl_mult <= ~w_hit_div;
                        md.md_ctrl_div  <= w_hit_div;
                        r_state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (flush) begin
                        r_state <= md.md_resultRDY ? S_IDLE : S_DRAIN;
                    end else if (md.md_resultRDY) begin
                        r_state      <= S_DONE;
                        result_valid <= 1'b1;
                        if (md.md_exception) begin
                            result          <= r_is_div ? DIV_STATUS : MUL_STATUS;
                            result_rd       <= c_STATUS_RD;
                            exception_valid <= 1'b1;
                        end else begin
                            result          <= md.md_result;
                            result_rd       <= r_rd;
                            exception_valid <= 1'b0;
                        end
                    end else if (w_timeout) begin
`ifdef MULTDIV_TIMEOUT_EN
                        r_state         <= S_DONE;
                        result_valid    <= 1'b1;
                        result          <= TIMEOUT_STATUS;
                        result_rd       <= c_STATUS_RD;
                        exception_valid <= 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    // Result belongs to a committed insn: flush is not honoured here.
                    result_valid    <= 1'b0;
                    exception_valid <= 1'b0;
                    r_state         <= S_IDLE;
                end
                S_DRAIN: begin
                    if (md.md_resultRDY || w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_execute_multdiv_ctrl.sv
// ============================================================================
// Module   : tb_execute_multdiv_ctrl
// Brief    : Scoreboard bench for execute_multdiv_ctrl (timeout case runs when
//            MULTDIV_TIMEOUT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_multdiv_ctrl;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        exc;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        insn_valid;
    logic [31:0] insn;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        flush;
    logic        stall;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  result_rd;
    logic        exception_valid;
    logic        busy;

    execute_multdiv_ctrl_if mdif();

    execute_multdiv_ctrl #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .insn_valid      (insn_valid),
        .insn            (insn),
        .operandA        (operandA),
        .operandB        (operandB),
        .flush           (flush),
        .md              (mdif),
        .stall           (stall),
        .result_valid    (result_valid),
        .result          (result),
        .result_rd       (result_rd),
        .exception_valid (exception_valid),
        .busy            (busy)
    );

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_pulses  = 0;
    int   n_issued  = 0;
    exp_t sb[$];
    exp_t mon_e;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_insn(input bit is_div, input logic [4:0] rd);
        logic [31:0] w;
        w        = 32'd0;
        w[26:22] = rd;
        w[6:2]   = is_div ? 5'b00111 : 5'b00110;
        return w;
    endfunction

    // Scoreboard consumer plus start-pulse counter.
    always @(negedge clock) begin
        if (mdif.md_ctrl_mult || mdif.md_ctrl_div) n_pulses++;
        if (reset_n && result_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(result_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("result", result, mon_e.res);
                check("result_rd", 32'(result_rd), 32'(mon_e.rd));
                check("exception_valid", 32'(exception_valid), 32'(mon_e.exc));
            end
        end
    end

    task automatic bubble();
        @(posedge clock); #1;
        insn_valid = 1'b0;
        insn       = 32'd0;
        flush      = 1'b0;
    endtask

    // One full operation: detect, ISSUE, lat WAIT cycles (RDY in the last unless rdy=0), DONE.
    task automatic run_op(input bit is_div, input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input bit rdy, input bit exc);
        logic [31:0] res;
        exp_t        e;
        int          stalls;
        res = is_div ? ((b != 0) ? a / b : 32'hDEAD_BEEF) : a * b;
        if (!rdy)     e = '{32'd6, 5'd30, 1'b1};
        else if (exc) e = '{(is_div ? 32'd5 : 32'd4), 5'd30, 1'b1};
        else          e = '{res, rd, 1'b0};
        sb.push_back(e);
        n_issued++;
        stalls = 0;
        @(posedge clock); #1;
        insn_valid = 1'b1;
        insn       = mk_insn(is_div, rd);
        operandA   = a;
        operandB   = b;
        @(negedge clock);
        if (stall) stalls++;
        @(posedge clock); #1;
        operandA = ~a;
        operandB = ~b;
        @(negedge clock);
        if (stall) stalls++;
        check("start_mul", 32'(mdif.md_ctrl_mult), 32'(!is_div));
        check("start_div", 32'(mdif.md_ctrl_div), 32'(is_div));
        for (int i = 1; i <= lat; i++) begin
            @(posedge clock); #1;
            if (i == lat && rdy) begin
                mdif.md_resultRDY = 1'b1;
                mdif.md_result    = res;
                mdif.md_exception = exc;
            end
            @(negedge clock);
            if (stall) stalls++;
            if (i == 1) begin
                check("latched_opA", mdif.md_operandA, a);
                check("latched_opB", mdif.md_operandB, b);
                check("start_low_in_wait", 32'(mdif.md_ctrl_mult | mdif.md_ctrl_div), 32'd0);
            end
        end
        @(posedge clock); #1;
        mdif.md_resultRDY = 1'b0;
        mdif.md_result    = 32'd0;
        mdif.md_exception = 1'b0;
        @(negedge clock);
        check("done_result_valid", 32'(result_valid), 32'd1);
        check("done_stall_low", 32'(stall), 32'd0);
        check("stall_cycles", 32'(stalls), 32'(lat + 2));
    endtask

    initial begin
        reset_n           = 1'b0;
        insn_valid        = 1'b0;
        insn              = 32'd0;
        operandA          = 32'd0;
        operandB          = 32'd0;
        flush             = 1'b0;
        mdif.md_resultRDY = 1'b0;
        mdif.md_result    = 32'd0;
        mdif.md_exception = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_opA", mdif.md_operandA, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        run_op(1'b0, 5'd5, 32'd7, 32'd6, 32, 1'b1, 1'b0);
        bubble();
        run_op(1'b1, 5'd9, 32'd100, 32'd0, 5, 1'b1, 1'b1);
        bubble();

        // Back-to-back: the div is in execute the cycle after the mul's DONE.
        run_op(1'b0, 5'd3, 32'd12, 32'd11, 4, 1'b1, 1'b0);
        run_op(1'b1, 5'd4, 32'd1000, 32'd7, 6, 1'b1, 1'b0);
        bubble();
        @(negedge clock);
        check("b2b_idle", 32'(busy), 32'd0);
        check("b2b_pulses", 32'(n_pulses), 32'(n_issued));

        // md insn arriving together with a flush is dropped.
        @(posedge clock); #1;
        insn_valid = 1'b1;
        insn       = mk_insn(1'b0, 5'd2);
        flush      = 1'b1;
        @(negedge clock);
        check("flush_idle_stall", 32'(stall), 32'd0);
        bubble();
        @(negedge clock);
        check("flush_idle_busy", 32'(busy), 32'd0);

        // Flush in the 3rd WAIT cycle, then a late RDY absorbed by DRAIN.
        @(posedge clock); #1;
        insn_valid = 1'b1;
        insn       = mk_insn(1'b0, 5'd6);
        operandA   = 32'd3;
        operandB   = 32'd3;
        n_issued++;
        repeat (3) begin @(posedge clock); #1; end
        @(posedge clock); #1;
        flush = 1'b1;
        @(negedge clock);
        check("flush_wait_stall", 32'(stall), 32'd1);
        @(posedge clock); #1;
        flush      = 1'b0;
        insn_valid = 1'b0;
        @(negedge clock);
        check("drain_stall_low", 32'(stall), 32'd0);
        check("drain_busy", 32'(busy), 32'd1);
        @(posedge clock); #1;
        insn_valid = 1'b1;
        insn       = mk_insn(1'b0, 5'd7);
        @(negedge clock);
        check("drain_stall_hit", 32'(stall), 32'd1);
        check("drain_no_start", 32'(mdif.md_ctrl_mult), 32'd0);
        @(posedge clock); #1;
        mdif.md_resultRDY = 1'b1;
        mdif.md_result    = 32'd9;
        insn_valid        = 1'b0;
        @(posedge clock); #1;
        mdif.md_resultRDY = 1'b0;
        @(negedge clock);
        check("drain_to_idle", 32'(busy), 32'd0);
        check("drain_no_result", 32'(result_valid), 32'd0);

        // Flush coinciding with RDY in WAIT discards the result.
        @(posedge clock); #1;
        insn_valid = 1'b1;
        insn       = mk_insn(1'b1, 5'd8);
        n_issued++;
        @(posedge clock); #1;
        insn_valid = 1'b0;
        @(posedge clock); #1;
        flush             = 1'b1;
        mdif.md_resultRDY = 1'b1;
        @(posedge clock); #1;
        flush             = 1'b0;
        mdif.md_resultRDY = 1'b0;
        @(negedge clock);
        check("flush_rdy_idle", 32'(busy), 32'd0);
        check("flush_rdy_no_result", 32'(result_valid), 32'd0);

        // Asynchronous reset in WAIT with the insn still present.
        @(posedge clock); #1;
        insn_valid = 1'b1;
        insn       = mk_insn(1'b0, 5'd8);
        operandA   = 32'd2;
        operandB   = 32'd2;
        n_issued++;
        repeat (3) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_result_rd", 32'(result_rd), 32'd0);
        check("arst_opA", mdif.md_operandA, 32'd0);
        @(posedge clock); #1;
        reset_n    = 1'b1;
        insn_valid = 1'b0;
        run_op(1'b0, 5'd10, 32'd9, 32'd9, 3, 1'b1, 1'b0);
        bubble();

`ifdef MULTDIV_TIMEOUT_EN
        run_op(1'b0, 5'd11, 32'd1, 32'd1, 8, 1'b0, 1'b0);
        bubble();
`endif
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("total_pulses", 32'(n_pulses), 32'(n_issued));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
